// File: rtl/button_debouncer_if.sv
// Button conditioner bundle: raw active-low buttons in, debounced level and
// one-cycle press/release pulses out. The master side is the board/consumer,
// the slave side is the debouncer itself.
interface button_debouncer_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;      // 0 = pressed, asynchronous to clk
  logic [N_BTN-1:0] btn_level;    // 1 = pressed, debounced
  logic [N_BTN-1:0] btn_press;    // one-cycle pulse on accepted press
  logic [N_BTN-1:0] btn_release;  // one-cycle pulse on accepted release
  logic             any_press;    // OR of btn_press

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner. Each channel runs a two-flop
// synchronizer followed by an independent four-state debounce FSM with its
// own stability counter. A new level is accepted only after the synchronized
// input has held it for DEBOUNCE_CYCLES+1 consecutive samples; any reversal
// while checking drops back to the previous stable state without a pulse.
module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_CHK_UP = 2'd3
  } state_e;

  // Terminal count: the state changes on the sample where the counter
  // already equals this value, giving DEBOUNCE_CYCLES+1 stable samples.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s0_q, s0_d;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

  // Next-state, counter and output-pulse computation for every channel.
  always_comb begin
    s1_d      = bus.btn_raw;
    s0_d      = s1_q;
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_UP: begin
          if (s0_q[i] == 1'b0) begin
            state_d[i] = ST_CHK_DN;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_UP;
          end
        end
        ST_CHK_DN: begin
          if (s0_q[i] == 1'b1) begin
            state_d[i] = ST_UP;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ST_DOWN;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (s0_q[i] == 1'b1) begin
            state_d[i] = ST_CHK_UP;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_DOWN;
          end
        end
        ST_CHK_UP: begin
          if (s0_q[i] == 1'b0) begin
            state_d[i] = ST_DOWN;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ST_UP;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
        end
      endcase
      // Outputs are derived from the next state so they change on the same
      // edge the FSM does.
      level_d[i]   = (state_d[i] == ST_DOWN) || (state_d[i] == ST_CHK_UP);
      press_d[i]   = (state_q[i] == ST_CHK_DN) && (state_d[i] == ST_DOWN);
      release_d[i] = (state_q[i] == ST_CHK_UP) && (state_d[i] == ST_UP);
    end
  end

  // Synchronizer, FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '1;
      s0_q      <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_UP;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = |press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3,
// N_BTN=5. The reference model tracks, per channel, how many consecutive
// samples the synchronized input has shown the same value and accepts a new
// level once that run reaches DEBOUNCE_CYCLES+1.
module tb_button_debouncer;

  localparam int N   = 5;
  localparam int D   = 4;
  localparam int CW  = 3;

  logic clk;
  logic reset;

  button_debouncer_if #(.N_BTN(N)) bus ();

  button_debouncer #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [N-1:0] m_s1, m_s0, m_prev_v, m_level, m_press, m_rel;
  int           m_run [N];

  task automatic model_init();
    m_s1     = '1;
    m_s0     = '1;
    m_prev_v = '1;
    m_level  = '0;
    m_press  = '0;
    m_rel    = '0;
    for (int i = 0; i < N; i++) m_run[i] = D + 2;
  endtask

  // Advance one clock edge in both DUT and model, then settle for sampling.
  task automatic tick();
    logic [N-1:0] v;
    @(posedge clk);
    v       = m_s0;
    m_s0    = m_s1;
    m_s1    = bus.btn_raw;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] == m_prev_v[i]) begin
        if (m_run[i] < D + 2) m_run[i] = m_run[i] + 1;
      end else begin
        m_run[i] = 1;
      end
      m_prev_v[i] = v[i];
      if ((!v[i]) != m_level[i] && m_run[i] == D + 1) begin
        m_level[i] = !v[i];
        if (!v[i]) m_press[i] = 1'b1;
        else       m_rel[i]   = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    bus.btn_raw = '1;
    reset = 1'b1;
    #3;
    n_tests++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press});
    end
    do_reset();
  endtask

  task automatic test_clean_press();
    do_reset();
    bus.btn_raw = 5'b11110;
    for (int k = 0; k <= 12; k++) begin
      tick();
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL clean_press_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
      if (k == 6) begin
        n_tests++;
        if (bus.btn_level !== 5'b00001 || bus.btn_press !== 5'b00001 || bus.any_press !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_press_E6 level=%b press=%b any=%b exp 00001/00001/1",
                   bus.btn_level, bus.btn_press, bus.any_press);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (bus.btn_press !== 5'b00000 || bus.any_press !== 1'b0 || bus.btn_level !== 5'b00001) begin
          n_fail++;
          $display("FAIL clean_press_E7 level=%b press=%b any=%b exp 00001/00000/0",
                   bus.btn_level, bus.btn_press, bus.any_press);
        end
      end
    end
  endtask

  // Continues from the held press left by test_clean_press.
  task automatic test_release();
    bus.btn_raw = 5'b11111;
    for (int k = 0; k <= 10; k++) begin
      tick();
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL release_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
      if (k == 5) begin
        n_tests++;
        if (bus.btn_level !== 5'b00001 || bus.btn_release !== 5'b00000) begin
          n_fail++;
          $display("FAIL release_E5 level=%b rel=%b exp 00001/00000", bus.btn_level, bus.btn_release);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (bus.btn_level !== 5'b00000 || bus.btn_release !== 5'b00001) begin
          n_fail++;
          $display("FAIL release_E6 level=%b rel=%b exp 00000/00001", bus.btn_level, bus.btn_release);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (bus.btn_level !== 5'b00000 || bus.btn_release !== 5'b00000) begin
          n_fail++;
          $display("FAIL release_E7 level=%b rel=%b exp 00000/00000", bus.btn_level, bus.btn_release);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int presses;
    do_reset();
    presses = 0;
    for (int k = 0; k < 16; k++) begin
      bus.btn_raw = (k < 3) ? 5'b11101 : 5'b11111;
      tick();
      if (bus.btn_press[1] === 1'b1) presses++;
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL bounce_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
    end
    n_tests++;
    if (presses !== 0 || bus.btn_level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_no_press presses=%0d level1=%b exp 0/0", presses, bus.btn_level[1]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.btn_raw = 5'b00110;
    for (int k = 0; k <= 8; k++) begin
      tick();
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL simul_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
      n_tests++;
      if (bus.btn_press !== ((k == 6) ? 5'b11001 : 5'b00000)) begin
        n_fail++;
        $display("FAIL simul_press k=%0d got=%b exp=%b", k, bus.btn_press,
                 (k == 6) ? 5'b11001 : 5'b00000);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit;
    do_reset();
    bus.btn_raw = 5'b11011;
    for (int k = 0; k <= 3; k++) tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%b exp=0",
               {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press});
    end
    #1 reset = 1'b0;
    model_init();
    hit = -1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (bus.btn_press[2] === 1'b1 && hit < 0) hit = k;
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL reset_mid_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
    end
    n_tests++;
    if (hit !== 6) begin
      n_fail++;
      $display("FAIL reset_mid_press_edge got=%0d exp=6", hit);
    end
  endtask

  task automatic test_long_hold();
    int presses;
    do_reset();
    presses = 0;
    bus.btn_raw = 5'b10111;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (bus.btn_press[3] === 1'b1) presses++;
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL long_hold_model k=%0d got=%b exp=%b", k,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
    end
    n_tests++;
    if (presses !== 1 || bus.btn_level[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL long_hold_once presses=%0d level3=%b exp 1/1", presses, bus.btn_level[3]);
    end
  endtask

  task automatic test_random();
    int hold [N];
    int presses;
    do_reset();
    presses = 0;
    bus.btn_raw = '1;
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 9);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          bus.btn_raw[i] = ~bus.btn_raw[i];
          hold[i] = $urandom_range(1, 9);
        end else begin
          hold[i] = hold[i] - 1;
        end
      end
      tick();
      if (bus.any_press === 1'b1) presses++;
      n_tests++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press} !==
          {m_level, m_press, m_rel, |m_press}) begin
        n_fail++;
        $display("FAIL random_model k=%0d raw=%b got=%b exp=%b", k, bus.btn_raw,
                 {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
                 {m_level, m_press, m_rel, |m_press});
      end
    end
    n_tests++;
    if (presses == 0) begin
      n_fail++;
      $display("FAIL random_activity presses=%0d exp >0", presses);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_raw = '1;
    model_init();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
